wb_cache: RTL and testbench

WB_CACHE -- requirements
Module: wb_cache

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_line_store.sv | 52 +++++
 rtl/wb_cache.sv | 234 +++++++++++++++++++++++
 tb/tb_wb_cache.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared FSM state type, default cache geometry and the saturating counter helper.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOOKUP    = 2'd1,
      WRITEBACK = 2'd2,
      REFILL    = 2'd3
   } state_e;

   localparam int LINES_DEF  = 256;
   localparam int WORDS_DEF  = 4;
   localparam int ADDR_W_DEF = 32;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data arrays: combinational read of one line/word, synchronous writes.
// Valid and dirty bits reset asynchronously; tag and data arrays are left uninitialised.
module cache_line_store #(
   parameter int LINES  = 256,
   parameter int WORDS  = 4,
   parameter int TAG_W  = 20,
   parameter int IDX_W  = 8,
   parameter int WSEL_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic [WSEL_W-1:0] rd_word_i,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic              rd_valid_o,
   output logic              rd_dirty_o,
   output logic [31:0]       rd_data_o,
   input  logic              wr_en_i,
   input  logic [WSEL_W-1:0] wr_word_i,
   input  logic [31:0]       wr_data_i,
   input  logic              tv_en_i,
   input  logic [TAG_W-1:0]  tv_tag_i,
   input  logic              dirty_en_i,
   input  logic              dirty_val_i
);

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES][WORDS];

   assign rd_tag_o   = tag_q[idx_i];
   assign rd_valid_o = valid_q[idx_i];
   assign rd_dirty_o = dirty_q[idx_i];
   assign rd_data_o  = data_q[idx_i][rd_word_i];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (tv_en_i) valid_q[idx_i] <= 1'b1;
         if (dirty_en_i) dirty_q[idx_i] <= dirty_val_i;
      end
   end

   always_ff @(posedge clk) begin
      if (tv_en_i) tag_q[idx_i] <= tv_tag_i;
      if (wr_en_i) data_q[idx_i][wr_word_i] <= wr_data_i;
   end

endmodule

// File: rtl/wb_cache.sv
// Direct-mapped write-back, write-allocate cache; hits answer 2 cycles after the request is sampled.
// Misses stall the CPU through word-serial write-back/refill bursts paced by mem_ready.
module wb_cache
   import cache_pkg::*;
#(
   parameter int LINES  = LINES_DEF,
   parameter int WORDS  = WORDS_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int OFF_W  = $clog2(WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
   localparam int WSEL_W = (OFF_W > 0) ? OFF_W : 1;
   localparam int WA_W   = ADDR_W - 2;

   state_e            state_q, state_d;
   logic [WA_W-1:0]   addr_q, addr_d;
   logic              we_q, we_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [WSEL_W-1:0] cnt_q, cnt_d;
   logic              refilled_q, refilled_d;
   logic              cpu_ready_q, cpu_ready_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       hit_q, hit_d, miss_q, miss_d;

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [WSEL_W-1:0] word_sel;
   logic [TAG_W-1:0]  rd_tag;
   logic              rd_valid, rd_dirty;
   logic [31:0]       rd_data;
   logic [WSEL_W-1:0] rd_word, wr_word;
   logic              wr_en, tv_en, dirty_en, dirty_val;
   logic [31:0]       wr_data;
   logic              hit, last_word;
   logic [ADDR_W-1:0] line_base, victim_base;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[1:0];
   assign idx = addr_q[OFF_W +: IDX_W];
   assign tag = addr_q[OFF_W+IDX_W +: TAG_W];

   if (OFF_W > 0) begin : g_word_sel
      assign word_sel = addr_q[WSEL_W-1:0];
   end else begin : g_single_word
      assign word_sel = '0;
   end

   assign hit         = rd_valid && (rd_tag == tag);
   assign last_word   = (cnt_q == WSEL_W'(WORDS - 1));
   assign line_base   = ADDR_W'({tag, idx}) << (OFF_W + 2);
   assign victim_base = ADDR_W'({rd_tag, idx}) << (OFF_W + 2);

   cache_line_store #(
      .LINES(LINES), .WORDS(WORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .WSEL_W(WSEL_W)
   ) u_store (
      .clk(clk), .reset(reset), .idx_i(idx), .rd_word_i(rd_word),
      .rd_tag_o(rd_tag), .rd_valid_o(rd_valid), .rd_dirty_o(rd_dirty), .rd_data_o(rd_data),
      .wr_en_i(wr_en), .wr_word_i(wr_word), .wr_data_i(wr_data),
      .tv_en_i(tv_en), .tv_tag_i(tag), .dirty_en_i(dirty_en), .dirty_val_i(dirty_val)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         refilled_q  <= 1'b0;
         cpu_ready_q <= 1'b0;
         cpu_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         refilled_q  <= refilled_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_rdata_q <= cpu_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      refilled_d  = refilled_q;
      cpu_ready_d = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      rd_word     = cnt_q;
      wr_en       = 1'b0;
      wr_word     = cnt_q;
      wr_data     = mem_rdata;
      tv_en       = 1'b0;
      dirty_en    = 1'b0;
      dirty_val   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // The ready cycle still sees the old request; ignore it.
            if (cpu_req && !cpu_ready_q) begin
               addr_d  = cpu_addr[ADDR_W-1:2];
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               rd_word     = word_sel;
               cpu_ready_d = 1'b1;
               cpu_rdata_d = rd_data;
               if (we_q) begin
                  wr_en     = 1'b1;
                  wr_word   = word_sel;
                  wr_data   = wdata_q;
                  dirty_en  = 1'b1;
                  dirty_val = 1'b1;
               end
               if (!refilled_q) hit_d = sat_inc(hit_q);
               refilled_d = 1'b0;
               state_d    = IDLE;
            end else begin
               // Word 0 of the victim is read now so the first write-back word is registered on entry.
               rd_word   = '0;
               miss_d    = sat_inc(miss_q);
               cnt_d     = '0;
               mem_req_d = 1'b1;
               if (rd_valid && rd_dirty) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = victim_base;
                  mem_wdata_d = rd_data;
                  state_d     = WRITEBACK;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = line_base;
                  state_d    = REFILL;
               end
            end
         end
         WRITEBACK: begin
            rd_word = cnt_q + WSEL_W'(1);
            if (mem_req_q && mem_ready) begin
               if (last_word) begin
                  dirty_en   = 1'b1;
                  dirty_val  = 1'b0;
                  cnt_d      = '0;
                  mem_we_d   = 1'b0;
                  mem_addr_d = line_base;
                  state_d    = REFILL;
               end else begin
                  cnt_d       = cnt_q + WSEL_W'(1);
                  mem_addr_d  = mem_addr_q + ADDR_W'(4);
                  mem_wdata_d = rd_data;
               end
            end
         end
         REFILL: begin
            if (mem_req_q && mem_ready) begin
               wr_en   = 1'b1;
               wr_word = cnt_q;
               wr_data = mem_rdata;
               if (last_word) begin
                  tv_en      = 1'b1;
                  dirty_en   = 1'b1;
                  dirty_val  = 1'b0;
                  cnt_d      = '0;
                  mem_req_d  = 1'b0;
                  refilled_d = 1'b1;
                  state_d    = LOOKUP;
               end else begin
                  cnt_d      = cnt_q + WSEL_W'(1);
                  mem_addr_d = mem_addr_q + ADDR_W'(4);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cpu_ready  = cpu_ready_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_wb_cache.sv
// Scoreboard bench for wb_cache (16 lines x 4 words) with a slow (ready after 3 cycles) or always-ready memory.
module tb_wb_cache;

   localparam int LINES  = 16;
   localparam int WORDS  = 4;
   localparam int ADDR_W = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic [31:0] hit_count, miss_count;

   wb_cache #(.LINES(LINES), .WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct {
      logic        chk_data;
      logic [31:0] data;
      logic [31:0] hits;
      logic [31:0] misses;
   } cpu_exp_t;

   mem_exp_t exp_mem[$];
   cpu_exp_t exp_cpu[$];
   int       n_vec = 0;
   int       n_err = 0;
   bit       fast  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_m(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      mem_exp_t e;
      e.we = we; e.addr = addr; e.wdata = wd;
      exp_mem.push_back(e);
   endtask

   task automatic push_rd(input logic [31:0] base);
      for (int i = 0; i < 4; i++) push_m(1'b0, base + 32'(4 * i), 32'h0);
   endtask

   task automatic push_c(input logic cd, input logic [31:0] d, input logic [31:0] h, input logic [31:0] m);
      cpu_exp_t c;
      c.chk_data = cd; c.data = d; c.hits = h; c.misses = m;
      exp_cpu.push_back(c);
   endtask

   // Memory model and memory-side monitor: the transfer that will complete at the next
   // rising edge is known at the falling edge, so it is checked and applied there.
   initial begin : mem_model
      logic [31:0] mem [0:511];
      int          wcnt;
      mem_exp_t    e;
      wcnt = 0;
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         mem[64 + i]  = 32'hA0 + 32'(i);
         mem[320 + i] = 32'hB0 + 32'(i);
         mem[128 + i] = 32'hC0 + 32'(i);
         mem[192 + i] = 32'hD0 + 32'(i);
         mem[256 + i] = 32'hE0 + 32'(i);
      end
      forever begin
         @(negedge clk);
         if (fast) begin
            mem_ready = 1'b1;
         end else if (reset || !mem_req) begin
            wcnt      = 0;
            mem_ready = 1'b0;
         end else begin
            if (mem_ready) wcnt = 0;
            wcnt++;
            mem_ready = (wcnt == 3);
         end
         if (mem_req && !mem_we) mem_rdata = mem[mem_addr[10:2]];
         if (mem_req && mem_ready && !reset) begin
            if (exp_mem.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL mem_unexpected: got transfer we=%0b addr=0x%08h, expected none", mem_we, mem_addr);
            end else begin
               e = exp_mem.pop_front();
               chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
               chk("mem_addr", mem_addr, e.addr);
               if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
            if (mem_we) mem[mem_addr[10:2]] = mem_wdata;
         end
      end
   end

   always @(negedge clk) begin : cpu_monitor
      cpu_exp_t c;
      if (!reset && cpu_ready) begin
         if (exp_cpu.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL cpu_unexpected: got cpu_ready=1, expected no response at %0t", $time);
         end else begin
            c = exp_cpu.pop_front();
            if (c.chk_data) chk("cpu_rdata", cpu_rdata, c.data);
            chk("hit_count", hit_count, c.hits);
            chk("miss_count", miss_count, c.misses);
         end
      end
   end

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_cyc, input bit hold);
      int n;
      bit done, saw_mreq;
      n = 0; done = 1'b0; saw_mreq = 1'b0;
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
         if (mem_req) saw_mreq = 1'b1;
         if (cpu_ready) done = 1'b1;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL access_timeout: got no cpu_ready for addr 0x%08h, expected one within 300 cycles", addr);
      end else if (exp_cyc > 0) begin
         chk("latency", 32'(n), 32'(exp_cyc));
         if (exp_cyc == 2) chk("hit_mem_req", {31'b0, saw_mreq}, 32'h0);
      end
      if (hold) @(negedge clk);
      cpu_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin : stimulus
      int n;
      reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
      chk("rst_cpu_rdata", cpu_rdata, 32'h0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_hit_count", hit_count, 32'h0);
      chk("rst_miss_count", miss_count, 32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Cold read miss, then hit on the same line.
      push_rd(32'h100);
      push_c(1'b1, 32'hA0, 32'd0, 32'd1);
      access(1'b0, 32'h100, 32'h0, 0, 1'b0);
      push_c(1'b1, 32'hA2, 32'd1, 32'd1);
      access(1'b0, 32'h108, 32'h0, 2, 1'b0);

      // Write hit dirties the line; a conflicting read writes it back first.
      push_c(1'b0, 32'h0, 32'd2, 32'd1);
      access(1'b1, 32'h104, 32'hDEAD_BEEF, 2, 1'b0);
      push_m(1'b1, 32'h100, 32'hA0);
      push_m(1'b1, 32'h104, 32'hDEAD_BEEF);
      push_m(1'b1, 32'h108, 32'hA2);
      push_m(1'b1, 32'h10C, 32'hA3);
      push_rd(32'h500);
      push_c(1'b1, 32'hB1, 32'd2, 32'd2);
      access(1'b0, 32'h504, 32'h0, 0, 1'b0);

      // Write miss to a clean line: refill only, then the store lands.
      push_rd(32'h200);
      push_c(1'b0, 32'h0, 32'd2, 32'd3);
      access(1'b1, 32'h20C, 32'h1234, 0, 1'b0);
      push_c(1'b1, 32'h1234, 32'd3, 32'd3);
      access(1'b0, 32'h20C, 32'h0, 2, 1'b1);

      // Evicting the dirty 0x200 line; refilled 0x100 line must carry the earlier store.
      push_m(1'b1, 32'h200, 32'hC0);
      push_m(1'b1, 32'h204, 32'hC1);
      push_m(1'b1, 32'h208, 32'hC2);
      push_m(1'b1, 32'h20C, 32'h1234);
      push_rd(32'h100);
      push_c(1'b1, 32'hDEAD_BEEF, 32'd3, 32'd4);
      access(1'b0, 32'h104, 32'h0, 0, 1'b0);

      // Always-ready memory: 4 back-to-back refill words.
      fast = 1'b1;
      push_rd(32'h300);
      push_c(1'b1, 32'hD3, 32'd3, 32'd5);
      access(1'b0, 32'h30C, 32'h0, 7, 1'b0);
      fast = 1'b0;
      repeat (2) @(negedge clk);

      // Reset while the second refill word is outstanding.
      push_m(1'b0, 32'h400, 32'h0);
      cpu_we = 1'b0; cpu_addr = 32'h400; cpu_req = 1'b1;
      n = 0;
      while (!(mem_req && mem_addr == 32'h404) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_vec++;
         n_err++;
         $display("FAIL abort_wait: got no second refill word, expected mem_addr 0x00000404");
      end
      reset = 1'b1;
      cpu_req = 1'b0;
      #1;
      chk("abort_mem_req", {31'b0, mem_req}, 32'h0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      chk("abort_miss_count", miss_count, 32'h0);
      chk("abort_hit_count", hit_count, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      push_rd(32'h400);
      push_c(1'b1, 32'hE0, 32'd0, 32'd1);
      access(1'b0, 32'h400, 32'h0, 0, 1'b0);

      repeat (5) @(negedge clk);
      chk("mem_queue_left", 32'(exp_mem.size()), 32'h0);
      chk("cpu_queue_left", 32'(exp_cpu.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
